// File: rtl/select_pipeline.sv
// ---------------------------------------------------------------------------
// select_pipeline
//
// Registers CHANNELS input lanes of WIDTH bits and picks one lane per cycle.
// Selection is manual (explicit lane index) or round-robin over valid lanes.
// The chosen lane then travels through a DEPTH-stage output pipeline that
// carries valid, data and the granted channel index.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      asynchronous active-high reset
//   data_i     CHANNELS*WIDTH packed lanes, lane k at [k*WIDTH +: WIDTH]
//   valid_i    per-lane valid
//   select_i   lane index used in manual mode
//   auto_i     1 = round-robin mode, 0 = manual mode
//   data_o     selected data from the final pipeline stage
//   valid_o    data_o / channel_o are valid
//   channel_o  lane index carried in the final pipeline stage
// ---------------------------------------------------------------------------
module select_pipeline #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 2,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic [CHANNELS-1:0]       valid_i,
    input  logic [SEL_W-1:0]          select_i,
    input  logic                      auto_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      valid_o,
    output logic [SEL_W-1:0]          channel_o
);

    logic [CHANNELS*WIDTH-1:0] in_data_q;
    logic [CHANNELS-1:0]       in_valid_q;
    logic [SEL_W-1:0]          in_sel_q;
    logic                      in_auto_q;

    logic [SEL_W-1:0]          ptr_q;
    logic [SEL_W-1:0]          ptr_d;

    logic                      grant_valid;
    logic [SEL_W-1:0]          grant_idx;
    logic [WIDTH-1:0]          sel_data;

    logic                      stage_valid_q [DEPTH];
    logic [WIDTH-1:0]          stage_data_q  [DEPTH];
    logic [SEL_W-1:0]          stage_chan_q  [DEPTH];

    // Input registers and the round-robin pointer. The lane choice is made
    // only from these registered values, never from the raw inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_data_q  <= '0;
            in_valid_q <= '0;
            in_sel_q   <= '0;
            in_auto_q  <= 1'b0;
            ptr_q      <= '0;
        end else begin
            in_data_q  <= data_i;
            in_valid_q <= valid_i;
            in_sel_q   <= select_i;
            in_auto_q  <= auto_i;
            ptr_q      <= ptr_d;
        end
    end

    // Grant logic. Manual mode leaves the pointer untouched; round-robin
    // scans from ptr upwards with wrap, and on a grant moves ptr to the lane
    // after the winner. Scan indices stay below CHANNELS because ptr is only
    // ever loaded with values in 0..CHANNELS-1.
    always_comb begin
        int              scan_idx;
        logic [SEL_W-1:0] scan_sel;
        grant_valid = 1'b0;
        grant_idx   = '0;
        ptr_d       = ptr_q;
        scan_idx    = 0;
        scan_sel    = '0;
        if (!in_auto_q) begin
            // Out-of-range selects (non power-of-2 CHANNELS) grant nothing.
            if (int'(in_sel_q) < CHANNELS) begin
                grant_idx   = in_sel_q;
                grant_valid = in_valid_q[in_sel_q];
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                scan_idx = int'(ptr_q) + i;
                if (scan_idx >= CHANNELS) begin
                    scan_idx = scan_idx - CHANNELS;
                end
                scan_sel = SEL_W'(scan_idx);
                if (!grant_valid && in_valid_q[scan_sel]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_sel;
                end
            end
            if (grant_valid) begin
                ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

    // Lane data multiplexer driven by the granted index.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == grant_idx) begin
                sel_data = in_data_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output pipeline. Valid bits shift every edge; data and channel only
    // load behind a valid bit so bubbles do not toggle the datapath.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_valid_q[s] <= 1'b0;
                stage_data_q[s]  <= '0;
                stage_chan_q[s]  <= '0;
            end
        end else begin
            stage_valid_q[0] <= grant_valid;
            if (grant_valid) begin
                stage_data_q[0] <= sel_data;
                stage_chan_q[0] <= grant_idx;
            end
            for (int s = 1; s < DEPTH; s++) begin
                stage_valid_q[s] <= stage_valid_q[s-1];
                if (stage_valid_q[s-1]) begin
                    stage_data_q[s] <= stage_data_q[s-1];
                    stage_chan_q[s] <= stage_chan_q[s-1];
                end
            end
        end
    end

    assign data_o    = stage_data_q[DEPTH-1];
    assign valid_o   = stage_valid_q[DEPTH-1];
    assign channel_o = stage_chan_q[DEPTH-1];

endmodule

// File: tb/tb_select_pipeline.sv
// ---------------------------------------------------------------------------
// tb_select_pipeline
//
// Directed test of select_pipeline. The main instance uses default
// parameters with a queue of expected results; a second instance uses
// CHANNELS=3, WIDTH=16, DEPTH=1 for the non power-of-2 cases.
// ---------------------------------------------------------------------------
module tb_select_pipeline;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [1:0] c;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] dataIn;
    logic [3:0]  validIn;
    logic [1:0]  selIn;
    logic        autoIn;
    logic [7:0]  dataOut;
    logic        validOut;
    logic [1:0]  chanOut;

    logic [47:0] swData;
    logic [2:0]  swValid;
    logic [1:0]  swSel;
    logic        swAuto;
    logic [15:0] swDataOut;
    logic        swValidOut;
    logic [1:0]  swChanOut;

    exp_t        expQ[$];
    int          total = 0;
    int          bad   = 0;
    int          modelPtr;
    logic [7:0]  lastData;
    logic [1:0]  lastChan;

    select_pipeline dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (dataIn),
        .valid_i   (validIn),
        .select_i  (selIn),
        .auto_i    (autoIn),
        .data_o    (dataOut),
        .valid_o   (validOut),
        .channel_o (chanOut)
    );

    select_pipeline #(.WIDTH(16), .CHANNELS(3), .DEPTH(1)) dutSweep (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (swData),
        .valid_i   (swValid),
        .select_i  (swSel),
        .auto_i    (swAuto),
        .data_o    (swDataOut),
        .valid_o   (swValidOut),
        .channel_o (swChanOut)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Clear the expected-result model after a reset: DEPTH bubbles precede
    // the first captured input on its way to the outputs.
    task automatic resetModel();
        expQ.delete();
        for (int i = 0; i < DEPTH; i++) expQ.push_back(exp_t'(0));
        modelPtr = 0;
        lastData = 8'h00;
        lastChan = 2'd0;
    endtask

    // Drive one cycle of inputs (caller is between edges), queue the
    // expected grant, clock once and compare the oldest expectation.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] v,
                                 input logic [1:0] s, input logic a, input string tag);
        exp_t e;
        int   idx;
        dataIn  = d;
        validIn = v;
        selIn   = s;
        autoIn  = a;
        e = exp_t'(0);
        if (!a) begin
            e.v = v[s];
            e.c = s;
            e.d = d[int'(s)*8 +: 8];
        end else begin
            for (int i = 0; i < 4; i++) begin
                idx = (modelPtr + i) % 4;
                if (!e.v && v[idx]) begin
                    e.v = 1'b1;
                    e.c = 2'(idx);
                    e.d = d[idx*8 +: 8];
                end
            end
            if (e.v) modelPtr = (int'(e.c) + 1) % 4;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        if (e.v) begin
            lastData = e.d;
            lastChan = e.c;
        end
        checkOutput({tag, "/valid"}, 32'(validOut), 32'(e.v));
        checkOutput({tag, "/data"},  32'(dataOut),  32'(lastData));
        checkOutput({tag, "/chan"},  32'(chanOut),  32'(lastChan));
    endtask

    initial begin
        rst     = 1'b0;
        dataIn  = '0;
        validIn = '0;
        selIn   = '0;
        autoIn  = 1'b0;
        swData  = '0;
        swValid = '0;
        swSel   = '0;
        swAuto  = 1'b0;
        resetModel();

        // Power-on reset, outputs must clear before any clock edge.
        #2 rst = 1'b1;
        #2;
        checkOutput("por/valid", 32'(validOut), 32'd0);
        checkOutput("por/data",  32'(dataOut),  32'd0);
        checkOutput("por/chan",  32'(chanOut),  32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        resetModel();

        // Manual latency: lane 2 = A5 appears three cycles later.
        applyStimulus(32'h00A5_0000, 4'b0100, 2'd2, 1'b0, "man_a5");
        applyStimulus(32'h0, 4'b0000, 2'd0, 1'b0, "idle1");
        applyStimulus(32'h0, 4'b0000, 2'd0, 1'b0, "idle2");

        // Manual select of an invalid lane: bubble, data/channel hold.
        applyStimulus(32'h4433_2211, 4'b1101, 2'd1, 1'b0, "man_inv");
        applyStimulus(32'h0, 4'b0000, 2'd0, 1'b0, "idle3");
        applyStimulus(32'h0, 4'b0000, 2'd0, 1'b0, "idle4");

        // Round-robin fairness with all lanes valid.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(32'h1312_1110, 4'b1111, 2'd0, 1'b1, "rr_fair");
        end

        // Park the pointer at 3, then skip and wrap over lanes 0 and 2.
        applyStimulus(32'h2423_2221, 4'b0100, 2'd0, 1'b1, "rr_park");
        applyStimulus(32'h3433_3231, 4'b0101, 2'd0, 1'b1, "rr_wrap0");
        applyStimulus(32'h3433_3231, 4'b0101, 2'd0, 1'b1, "rr_skip2");
        applyStimulus(32'h3433_3231, 4'b0101, 2'd0, 1'b1, "rr_lane0");
        applyStimulus(32'h5555_5555, 4'b0000, 2'd0, 1'b1, "rr_none");
        applyStimulus(32'h4443_4241, 4'b1111, 2'd0, 1'b1, "rr_hold");

        // Manual grant in between must not move the pointer.
        applyStimulus(32'h5453_5251, 4'b1000, 2'd3, 1'b0, "man_frz");
        applyStimulus(32'h6463_6261, 4'b1111, 2'd0, 1'b1, "rr_resume");
        applyStimulus(32'h7473_7271, 4'b1111, 2'd0, 1'b1, "rr_next");

        // Reset mid-stream while valid data is in flight.
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst/valid", 32'(validOut), 32'd0);
        checkOutput("mid_rst/data",  32'(dataOut),  32'd0);
        checkOutput("mid_rst/chan",  32'(chanOut),  32'd0);
        dataIn  = '0;
        validIn = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        resetModel();

        // First post-reset output valid three cycles after its input, and
        // the round-robin pointer restarts at lane 0.
        applyStimulus(32'h0000_3C00, 4'b0010, 2'd1, 1'b0, "post_man");
        applyStimulus(32'h8483_8281, 4'b1010, 2'd0, 1'b1, "post_rr1");
        applyStimulus(32'h8483_8281, 4'b1010, 2'd0, 1'b1, "post_rr3");
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(32'h0, 4'b0000, 2'd0, 1'b0, "drain");
        end

        // Parameter sweep instance: CHANNELS=3, WIDTH=16, DEPTH=1.
        swSel   = 2'd3;
        swValid = 3'b111;
        swAuto  = 1'b0;
        swData  = {16'hBEEF, 16'h2222, 16'h1111};
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("sw_sel3/valid_a", 32'(swValidOut), 32'd0);
        swSel   = 2'd2;
        swValid = 3'b100;
        @(posedge clk);
        #1;
        checkOutput("sw_sel3/valid_b", 32'(swValidOut), 32'd0);
        swValid = 3'b000;
        @(posedge clk);
        #1;
        checkOutput("sw_sel2/valid", 32'(swValidOut), 32'd1);
        checkOutput("sw_sel2/data",  32'(swDataOut),  32'hBEEF);
        checkOutput("sw_sel2/chan",  32'(swChanOut),  32'd2);

        // Round-robin wrap with three lanes: 0,1,2,0.
        swData = {16'h0102, 16'h0101, 16'h0100};
        swAuto = 1'b1;
        for (int k = 0; k < 5; k++) begin
            swValid = (k < 4) ? 3'b111 : 3'b000;
            @(posedge clk);
            #1;
            if (k >= 1) begin
                checkOutput("sw_rr/valid", 32'(swValidOut), 32'd1);
                checkOutput("sw_rr/chan",  32'(swChanOut),  32'((k - 1) % 3));
                checkOutput("sw_rr/data",  32'(swDataOut),  32'(16'h0100 + 16'((k - 1) % 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/select_pipeline.md
# select_pipeline

Parametrised successor to the two-stage pass-through/select path: registers `CHANNELS` input lanes of `WIDTH` bits and picks one lane per cycle. Selection is either by an explicit select or by a round-robin arbiter over valid lanes. The chosen lane passes through a `DEPTH`-stage output pipeline, with per-lane valid tracking and the granted channel index reported at the output. It sits between multi-lane producers and a single-lane consumer, and replaces the fixed 2:1 combinational select.

## Interface
Parameters:
- `WIDTH`, 8, data bits per lane (≥1)
- `CHANNELS`, 4, number of input lanes (≥2)
- `DEPTH`, 2, output pipeline stages after the select (≥1)
- `SEL_W`, derived = max(1, $clog2(CHANNELS)), select/channel index width

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `data_i`  in  CHANNELS*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- `valid_i`  in  CHANNELS  per-lane valid
- `select_i`  in  SEL_W  lane index used in manual mode
- `auto_i`  in  1  1 = round-robin mode, 0 = manual mode
- `data_o`  out  WIDTH  selected data, final pipeline stage
- `valid_o`  out  1  `data_o`/`channel_o` are valid
- `channel_o`  out  SEL_W  index of the lane carried in the final stage

## Operation
- **Input stage.** Every edge, capture `data_i`, `valid_i`, `select_i` and `auto_i` into input registers (`in_data`, `in_valid`, `in_sel`, `in_auto`). The lane choice is made combinationally from these registers only.
- **Manual mode (`in_auto`=0).**
  - If `in_sel` < CHANNELS: grant = `in_sel`; the stage-1 valid equals `in_valid[in_sel]`.
  - If `in_sel` ≥ CHANNELS (non-power-of-2 `CHANNELS`): no grant, stage-1 valid = 0.
  - Manual mode never changes the round-robin pointer.
- **Round-robin mode (`in_auto`=1).**
  - `ptr` (SEL_W bits, reset 0) is the highest-priority lane.
  - Scan lanes `ptr`, `ptr`+1, … mod CHANNELS; grant the first lane with `in_valid`=1.
  - On a grant g, `ptr` <= (g+1) mod CHANNELS. The wrap from CHANNELS-1 goes to 0.
  - With no valid lane: stage-1 valid = 0 and `ptr` holds.
- **Pipeline.**
  - Stages 1..DEPTH each hold {valid, data, channel}.
  - Valid bits shift every edge.
  - A stage's data and channel load only when the incoming valid is 1; otherwise they hold their previous value (no toggling on bubbles).
  - There is no backpressure; the pipeline never stalls.
- **Outputs.** Driven directly from stage DEPTH registers, with no combinational path from inputs.

## Timing
- **Latency.**
  - A lane presented in cycle c is captured at edge c and enters stage 1 at edge c+1.
  - It appears on the outputs in cycle c+DEPTH+1.
  - `select_i` and `auto_i` are aligned with the `data_i`/`valid_i` of the same cycle.
- **Throughput.** One grant per cycle, and one result per cycle sustained.
- **Reset.**
  - All registers clear immediately on `rst_i` assertion (asynchronous), including `ptr`, input registers and pipeline stages.
  - `data_o`=0, `valid_o`=0, `channel_o`=0 while `rst_i`=1.
  - Reset mid-stream drops all in-flight data; there is no partial output afterwards.
  - The first post-reset output can be valid no earlier than cycle DEPTH+1 after the first non-reset edge.
- **Mode switch.**
  - `auto_i` takes effect per cycle, aligned with its data.
  - Switching from manual to auto resumes from the retained `ptr`.
  - Switching from auto to manual leaves `ptr` frozen.
- **Simultaneous valid lanes.** In manual mode, non-selected lanes are dropped. In auto mode, non-granted lanes are dropped for that cycle; there is no per-lane buffering, so producers re-present data.
- **All lanes valid every cycle in auto mode.** Grants cycle 0,1,…,CHANNELS-1,0,… with no skips.

## Test plan
- **Reset mid-stream.** Defaults; stream valid data. Assert `rst_i` between edges. Required: `valid_o`, `data_o` and `channel_o` read 0 immediately. After release, the first output is valid in cycle 3 following the first new valid input.
- **Manual latency.** Defaults, `auto_i`=0, `select_i`=2, lane 2 = 0xA5 with `valid_i`=4'b0100 in cycle 0. Required: cycle 3 shows `data_o`=0xA5, `valid_o`=1, `channel_o`=2. Cycles 1–2 show `valid_o`=0.
- **Manual select of an invalid lane.** `select_i`=1 with `valid_i`=4'b1101. Required: `valid_o`=0 three cycles later, and `data_o`/`channel_o` hold their previous values.
- **Round-robin fairness.** `auto_i`=1, `valid_i`=4'b1111 held for 8 cycles, lane k data = 0x10+k. Required: `channel_o` sequence 0,1,2,3,0,1,2,3 starting in cycle 3, with `data_o` = 0x10..0x13 repeating.
- **Round-robin skip and wrap.** Starting from `ptr`=3, `valid_i`=4'b0101. Required: grant lane 0 (wrap), then lane 2, then lane 0. An all-zero `valid_i` cycle gives `valid_o`=0 and leaves `ptr` unchanged.
- **Parameter sweep.** `CHANNELS`=3, `WIDTH`=16, `DEPTH`=1, manual `select_i`=3. Required: `valid_o` stays 0. `select_i`=2 with valid lane data 0xBEEF yields `data_o`=0xBEEF and `channel_o`=2 in cycle 2.
